fifo_burst_reader: RTL and testbench
====================================

FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 4, the FIFO word width in bits.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 4, the FIFO address width (depth 2**ADDR_WIDTH).
REQ-003 The block SHALL have parameter BURST_LEN, default 4, the words per burst, legal range 1..2**ADDR_WIDTH.
REQ-004 The block SHALL have a single clock and an asynchronous, active-high reset, as follows: clk  in  1  the single clock; all state is sampled on its rising edge.
REQ-005 The block SHALL have the reset port: reset  in  1  asynchronous, active-high reset.
REQ-006 The block SHALL have the port: rd  out  1  FIFO pop strobe.
REQ-007 The block SHALL have the port: r_data  in  DATA_WIDTH  FIFO read data, valid one cycle after rd.
REQ-008 The block SHALL have the port: empty  in  1  FIFO empty flag.
REQ-009 The block SHALL have the port: word_count  in  ADDR_WIDTH+2  FIFO occupancy.
REQ-010 The block SHALL have the port: flush  in  1  level input; drain a partial burst.
REQ-011 The block SHALL have the port: m_data  out  DATA_WIDTH  stream data.
REQ-012 The block SHALL have the port: m_valid  out  1  stream valid.
REQ-013 The block SHALL have the port: m_ready  in  1  stream ready.
REQ-014 The block SHALL have the port: m_first  out  1  first word of the burst.
REQ-015 The block SHALL have the port: m_last  out  1  last word of the burst.
REQ-016 The block SHALL have the port: busy  out  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, BURST and DRAIN.
REQ-018 In IDLE, the FSM SHALL go to BURST when word_count >= BURST_LEN, latching target = BURST_LEN.
REQ-019 In IDLE, the FSM SHALL otherwise go to BURST when flush=1 and empty=0, latching target = word_count; the full-burst condition has priority.
REQ-020 In BURST, rd SHALL be 1 in a cycle only when issued < target and (reads in flight + buffer occupancy) < 2.
REQ-021 rd SHALL never be 1 in IDLE or DRAIN, and the total reads per burst SHALL never exceed target.
REQ-022 When the read that makes issued equal target is issued, the FSM SHALL go from BURST to DRAIN.
REQ-023 When the word with m_last is accepted (m_valid && m_ready), the FSM SHALL go from DRAIN to IDLE.
REQ-024 The block SHALL capture r_data into a 2-entry output buffer the cycle after rd; m_data/m_valid SHALL present the buffer head.
REQ-025 A transfer SHALL occur when m_valid && m_ready; m_data, m_first and m_last SHALL hold stable while m_valid=1 and m_ready=0.
REQ-026 m_first SHALL be 1 only on word index 0 of a burst, and m_last only on index target-1; with target=1 both SHALL be 1.
REQ-027 With m_ready held at 1 and the FIFO non-empty, the block SHALL sustain 1 word/cycle, with 2 cycles from the first rd to the first m_valid.
REQ-028 A simultaneous capture and transfer on a full buffer SHALL neither lose nor duplicate a word.
REQ-029 Deasserting flush during a burst SHALL NOT alter the latched target.
REQ-030 The counters issued and delivered SHALL be ADDR_WIDTH+2 bits wide and SHALL NOT wrap within a burst.

Reset
REQ-031 On reset=1, the block SHALL immediately set the state to IDLE and clear the buffer, counters and in-flight flag.
REQ-032 On reset, rd, m_valid, m_first, m_last and busy SHALL be 0, and m_data SHALL be 0.
REQ-033 Reset asserted mid-burst SHALL discard any partial burst; the block SHALL NOT emit a trailing m_last.

Configuration
REQ-034 With FIFO_READER_STATS_EN defined, the block SHALL add the output words_out (32 bits), counting accepted transfers, wrapping, and reset to 0.
REQ-035 With FIFO_READER_STATS_EN defined, the block SHALL add the output bursts_out (16 bits), counting accepted m_last words, wrapping, and reset to 0.
REQ-036 Without FIFO_READER_STATS_EN, those ports and counters SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-037 The package fifo_reader_pkg SHALL hold the state enum type (IDLE, BURST, DRAIN) and the stats width constants.
REQ-038 The 2-entry output buffer SHALL be the sub-module fifo_skid_buf, parameterised by DATA_WIDTH+2 (data, first, last).

Verification
REQ-039 Bench case 1: write 4 words 0..3 with m_ready=1 -> rd high for 4 cycles; m_data 0,1,2,3; m_first on 0; m_last on 3; busy then drops.
REQ-040 Bench case 2: write 16 words with m_ready=1 -> 4 bursts of 4 in order 0..15, with no gaps inside a burst.
REQ-041 Bench case 3: write 4 words, hold m_ready=0 for 6 cycles -> at most 2 rd pulses; m_data=0 stable; after release, words 0..3 with no loss.
REQ-042 Bench case 4: write 2 words, pulse flush -> a burst of 2 with m_first on 0 and m_last on 1; no rd while empty=1.
REQ-043 Bench case 5: assert reset after the second word of a burst -> outputs 0 and state IDLE next edge; with 4 words rewritten, a fresh burst starts with m_first.
REQ-044 Bench case 6 (FIFO_READER_STATS_EN defined): run case 2 -> words_out=16 and bursts_out=4.

Source files
------------

// File: rtl/fifo_reader_pkg.sv
// Shared types for the FIFO burst reader: FSM state encoding and stats counter widths.
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int STATS_WORDS_W  = 32;
  localparam int STATS_BURSTS_W = 16;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry output buffer between the FIFO read port and the stream interface.
module fifo_skid_buf #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             valid,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             do_pop;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    do_pop  = pop && (count_q != 2'd0);
    case ({push, do_pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = push_data;
        else                 tail_d = push_data;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        head_d  = tail_q;
        count_d = count_q - 2'd1;
      end
      // Simultaneous push and pop: occupancy unchanged, the queue shifts by one.
      2'b11: begin
        if (count_q == 2'd1) begin
          head_d = push_data;
        end else begin
          head_d = tail_q;
          tail_d = push_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head  = head_q;
  assign valid = (count_q != 2'd0);
  assign count = count_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Pops fixed-length (or flush-length) bursts from a FIFO and streams them out with first/last tags.
// Optional FIFO_READER_STATS_EN adds words_out/bursts_out transfer counters.
module fifo_burst_reader
  import fifo_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  rd,
  input  logic [DATA_WIDTH-1:0] r_data,
  input  logic                  empty,
  input  logic [ADDR_WIDTH+1:0] word_count,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_first,
  output logic                  m_last,
  output logic                  busy
`ifdef FIFO_READER_STATS_EN
  ,
  output logic [STATS_WORDS_W-1:0]  words_out,
  output logic [STATS_BURSTS_W-1:0] bursts_out
`endif
);

  localparam int CW = ADDR_WIDTH + 2;
  localparam int BW = DATA_WIDTH + 2;
  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t BURST_CNT = cnt_t'(BURST_LEN);
  localparam cnt_t ONE       = cnt_t'(1);

  state_e state_q, state_d;
  cnt_t   target_q, target_d;
  cnt_t   issued_q, issued_d;
  cnt_t   delivered_q, delivered_d;
  logic   inflight_q, inflight_d;
  logic   first_tag_q, first_tag_d;
  logic   last_tag_q, last_tag_d;
  logic   busy_q, busy_d;

  logic [BW-1:0] buf_head;
  logic          buf_valid;
  logic [1:0]    buf_count;
  logic [1:0]    occ_after;
  logic          xfer;

  assign xfer      = buf_valid && m_ready;
  // Count the slot freed by this cycle's transfer so a draining stream can sustain 1 word/cycle.
  assign occ_after = buf_count - {1'b0, xfer};
  assign rd        = (state_q == BURST) && (issued_q < target_q) && !empty &&
                     (({1'b0, inflight_q} + occ_after) < 2'd2);

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    issued_d    = issued_q;
    delivered_d = delivered_q;
    inflight_d  = rd;
    first_tag_d = (issued_q == '0);
    last_tag_d  = (issued_q == target_q - ONE);
    case (state_q)
      IDLE: begin
        if (word_count >= BURST_CNT) begin
          state_d     = BURST;
          target_d    = BURST_CNT;
          issued_d    = '0;
          delivered_d = '0;
        end else if (flush && !empty) begin
          state_d     = BURST;
          target_d    = word_count;
          issued_d    = '0;
          delivered_d = '0;
        end
      end
      BURST: begin
        if (xfer) delivered_d = delivered_q + ONE;
        if (rd) begin
          issued_d = issued_q + ONE;
          if (issued_q + ONE == target_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (xfer) begin
          delivered_d = delivered_q + ONE;
          if (delivered_q + ONE == target_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      target_q    <= '0;
      issued_q    <= '0;
      delivered_q <= '0;
      inflight_q  <= 1'b0;
      first_tag_q <= 1'b0;
      last_tag_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      issued_q    <= issued_d;
      delivered_q <= delivered_d;
      inflight_q  <= inflight_d;
      first_tag_q <= first_tag_d;
      last_tag_q  <= last_tag_d;
      busy_q      <= busy_d;
    end
  end

  fifo_skid_buf #(
    .WIDTH(BW)
  ) u_buf (
    .clk      (clk),
    .reset    (reset),
    .push     (inflight_q),
    .push_data({r_data, first_tag_q, last_tag_q}),
    .pop      (m_ready),
    .head     (buf_head),
    .valid    (buf_valid),
    .count    (buf_count)
  );

  assign m_data  = buf_head[BW-1:2];
  assign m_valid = buf_valid;
  assign m_first = buf_valid & buf_head[1];
  assign m_last  = buf_valid & buf_head[0];
  assign busy    = busy_q;

`ifdef FIFO_READER_STATS_EN
  logic [STATS_WORDS_W-1:0]  words_q, words_d;
  logic [STATS_BURSTS_W-1:0] bursts_q, bursts_d;

  always_comb begin
    words_d  = words_q;
    bursts_d = bursts_q;
    if (xfer) words_d = words_q + 1'b1;
    if (xfer && m_last) bursts_d = bursts_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      words_q  <= '0;
      bursts_q <= '0;
    end else begin
      words_q  <= words_d;
      bursts_q <= bursts_d;
    end
  end

  assign words_out  = words_q;
  assign bursts_out = bursts_q;
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a simple registered-read FIFO model in front of it.
module tb_fifo_burst_reader;

  logic       clk;
  logic       reset;
  logic       rd;
  logic [3:0] r_data;
  logic       empty;
  logic [5:0] word_count;
  logic       flush;
  logic [3:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_first;
  logic       m_last;
  logic       busy;
`ifdef FIFO_READER_STATS_EN
  logic [31:0] words_out;
  logic [15:0] bursts_out;
`endif

  logic       wr_en;
  logic [3:0] wr_data;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_burst_reader #(
    .DATA_WIDTH(4),
    .ADDR_WIDTH(4),
    .BURST_LEN (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rd        (rd),
    .r_data    (r_data),
    .empty     (empty),
    .word_count(word_count),
    .flush     (flush),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_first   (m_first),
    .m_last    (m_last),
    .busy      (busy)
`ifdef FIFO_READER_STATS_EN
    ,
    .words_out (words_out),
    .bursts_out(bursts_out)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FIFO model: registered read data, valid the cycle after rd.
  logic [3:0] mem [0:31];
  int wp, rp, cnt;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wp     <= 0;
      rp     <= 0;
      cnt    <= 0;
      r_data <= 4'd0;
    end else begin
      if (rd && cnt > 0) begin
        r_data <= mem[rp];
        rp     <= (rp + 1) % 32;
      end
      if (wr_en) begin
        mem[wp] <= wr_data;
        wp      <= (wp + 1) % 32;
      end
      cnt <= cnt + (wr_en ? 1 : 0) - ((rd && cnt > 0) ? 1 : 0);
    end
  end

  assign word_count = 6'(cnt);
  assign empty      = (cnt == 0);

  // Monitor: records accepted words {last, first, data}, their cycles, and rd activity.
  int         cyc = 0;
  int         rd_cnt = 0;
  int         rd_empty_cnt = 0;
  int         rdc[$];
  logic [5:0] xq[$];
  int         xc[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (!reset) begin
      if (rd) begin
        rd_cnt <= rd_cnt + 1;
        rdc.push_back(cyc);
        if (empty) rd_empty_cnt <= rd_empty_cnt + 1;
      end
      if (m_valid && m_ready) begin
        xq.push_back({m_last, m_first, m_data});
        xc.push_back(cyc);
      end
    end
  end

  task automatic write_words(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      wr_en   = 1'b1;
      wr_data = 4'(start + i);
    end
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_xfers(input int target, input int budget, output bit ok);
    for (int k = 0; k < budget && xq.size() < target; k++) begin
      @(negedge clk); #1;
    end
    ok = (xq.size() >= target);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if ({rd, m_valid, m_first, m_last, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got rd/valid/first/last/busy=%b want 00000", {rd, m_valid, m_first, m_last, busy});
    end
    n_checks++;
    if (m_data !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_data: got %0h want 0", m_data);
    end
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({rd, busy, m_valid} !== 3'b0) begin
      n_fail++;
      $display("FAIL reset_idle: got rd/busy/valid=%b want 000", {rd, busy, m_valid});
    end
  endtask

  task automatic test_back_to_back;
    int  xb, rb;
    bit  ok;
    logic [5:0] exp;
    xb = xq.size();
    rb = rd_cnt;
    m_ready = 1'b1;
    write_words(0, 16);
    wait_xfers(xb + 16, 200, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL b2b_timeout: got %0d words want 16", xq.size() - xb);
    end else begin
      for (int i = 0; i < 16; i++) begin
        exp = {(i % 4 == 3), (i % 4 == 0), 4'(i)};
        n_checks++;
        if (xq[xb + i] !== exp) begin
          n_fail++;
          $display("FAIL b2b_word%0d: got %b want %b", i, xq[xb + i], exp);
        end
        if (i % 4 != 3) begin
          n_checks++;
          if (xc[xb + i + 1] - xc[xb + i] != 1) begin
            n_fail++;
            $display("FAIL b2b_gap%0d: got %0d cycles want 1", i, xc[xb + i + 1] - xc[xb + i]);
          end
        end
      end
    end
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (rd_cnt - rb != 16) begin
      n_fail++;
      $display("FAIL b2b_rd_count: got %0d want 16", rd_cnt - rb);
    end
`ifdef FIFO_READER_STATS_EN
    n_checks++;
    if (words_out !== 32'd16) begin
      n_fail++;
      $display("FAIL stats_words: got %0d want 16", words_out);
    end
    n_checks++;
    if (bursts_out !== 16'd4) begin
      n_fail++;
      $display("FAIL stats_bursts: got %0d want 4", bursts_out);
    end
`endif
  endtask

  task automatic test_single_burst;
    int  xb, rb, rcb;
    bit  ok;
    logic [5:0] exp;
    xb  = xq.size();
    rb  = rd_cnt;
    rcb = rdc.size();
    m_ready = 1'b1;
    write_words(0, 4);
    wait_xfers(xb + 4, 50, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL single_timeout: got %0d words want 4", xq.size() - xb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp = {(i == 3), (i == 0), 4'(i)};
        n_checks++;
        if (xq[xb + i] !== exp) begin
          n_fail++;
          $display("FAIL single_word%0d: got %b want %b", i, xq[xb + i], exp);
        end
      end
      n_checks++;
      if (rdc[rcb + 3] - rdc[rcb] != 3) begin
        n_fail++;
        $display("FAIL single_rd_span: got %0d want 3", rdc[rcb + 3] - rdc[rcb]);
      end
      n_checks++;
      if (xc[xb] - rdc[rcb] != 2) begin
        n_fail++;
        $display("FAIL single_latency: got %0d want 2", xc[xb] - rdc[rcb]);
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_busy_drop: got %b want 0", busy);
    end
    n_checks++;
    if (rd_cnt - rb != 4) begin
      n_fail++;
      $display("FAIL single_rd_count: got %0d want 4", rd_cnt - rb);
    end
  endtask

  task automatic test_backpressure;
    int  xb, rb, k;
    bit  ok;
    logic [5:0] exp;
    xb = xq.size();
    rb = rd_cnt;
    @(posedge clk); #1;
    m_ready = 1'b0;
    write_words(0, 4);
    k = 0;
    while (!m_valid && k < 30) begin
      @(negedge clk); #1;
      k++;
    end
    n_checks++;
    if (!m_valid) begin
      n_fail++;
      $display("FAIL bp_valid_timeout: got m_valid=%b want 1", m_valid);
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #1;
      n_checks++;
      if ({m_valid, m_first, m_data} !== 6'b110000) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got valid/first/data=%b want 110000", i, {m_valid, m_first, m_data});
      end
    end
    n_checks++;
    if (rd_cnt - rb > 2 || rd_cnt - rb < 1) begin
      n_fail++;
      $display("FAIL bp_rd_limit: got %0d rd pulses want 1..2", rd_cnt - rb);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_xfers(xb + 4, 50, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL bp_timeout: got %0d words want 4", xq.size() - xb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp = {(i == 3), (i == 0), 4'(i)};
        n_checks++;
        if (xq[xb + i] !== exp) begin
          n_fail++;
          $display("FAIL bp_word%0d: got %b want %b", i, xq[xb + i], exp);
        end
      end
    end
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (xq.size() - xb != 4) begin
      n_fail++;
      $display("FAIL bp_word_total: got %0d want 4", xq.size() - xb);
    end
  endtask

  task automatic test_flush;
    int  xb, rb, eb;
    bit  ok;
    xb = xq.size();
    rb = rd_cnt;
    eb = rd_empty_cnt;
    m_ready = 1'b1;
    write_words(0, 2);
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_no_early_start: got busy=%b want 0", busy);
    end
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    wait_xfers(xb + 2, 50, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL flush_timeout: got %0d words want 2", xq.size() - xb);
    end else begin
      n_checks++;
      if (xq[xb] !== 6'b010000) begin
        n_fail++;
        $display("FAIL flush_word0: got %b want 010000", xq[xb]);
      end
      n_checks++;
      if (xq[xb + 1] !== 6'b100001) begin
        n_fail++;
        $display("FAIL flush_word1: got %b want 100001", xq[xb + 1]);
      end
    end
    repeat (4) @(negedge clk);
    #1;
    n_checks++;
    if (rd_cnt - rb != 2) begin
      n_fail++;
      $display("FAIL flush_rd_count: got %0d want 2", rd_cnt - rb);
    end
    n_checks++;
    if (rd_empty_cnt - eb != 0) begin
      n_fail++;
      $display("FAIL flush_rd_empty: got %0d want 0", rd_empty_cnt - eb);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_busy_drop: got %b want 0", busy);
    end
  endtask

  task automatic test_reset_mid_burst;
    int  xb;
    bit  ok;
    logic [5:0] exp;
    xb = xq.size();
    m_ready = 1'b1;
    write_words(0, 4);
    wait_xfers(xb + 2, 50, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rst_mid_timeout: got %0d words want 2", xq.size() - xb);
    end
    #1 reset = 1'b1;
    #1;
    n_checks++;
    if ({rd, m_valid, m_first, m_last, m_data} !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_mid_outputs: got %b want 00000000", {rd, m_valid, m_first, m_last, m_data});
    end
    @(posedge clk); #1;
    n_checks++;
    if ({busy, m_valid, rd} !== 3'b0) begin
      n_fail++;
      $display("FAIL rst_mid_idle: got busy/valid/rd=%b want 000", {busy, m_valid, rd});
    end
    @(negedge clk); #2;
    reset = 1'b0;
    xb = xq.size();
    write_words(0, 4);
    wait_xfers(xb + 4, 50, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL rst_fresh_timeout: got %0d words want 4", xq.size() - xb);
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp = {(i == 3), (i == 0), 4'(i)};
        n_checks++;
        if (xq[xb + i] !== exp) begin
          n_fail++;
          $display("FAIL rst_fresh_word%0d: got %b want %b", i, xq[xb + i], exp);
        end
      end
    end
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (xq.size() - xb != 4) begin
      n_fail++;
      $display("FAIL rst_fresh_total: got %0d words want 4", xq.size() - xb);
    end
  endtask

  initial begin
    reset   = 1'b1;
    wr_en   = 1'b0;
    wr_data = 4'd0;
    flush   = 1'b0;
    m_ready = 1'b1;
    test_reset;
    test_back_to_back;
    test_single_burst;
    test_backpressure;
    test_flush;
    test_reset_mid_burst;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
